fcore_run_sequencer: RTL and testbench

- Sits directly upstream of the fCore instance; it is the sole driver of the core's run input.
- On each trigger it pulses run and waits for done.
- It then reads a programmable list of result registers through the core's DMA read-request/response streams.
- It forwards each value as one output-stream beat tagged with its list index; the last beat carries tlast.

---
 rtl/fcore_sequencer_pkg.sv | 28 ++
 rtl/fcore_seq_addr_table.sv | 39 +++
 rtl/fcore_run_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_fcore_run_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcore_sequencer_pkg.sv
// Shared types and defaults for the fCore run sequencer.
package fcore_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    WAIT_DONE = 3'd2,
    REQ       = 3'd3,
    RESP      = 3'd4,
    OUT_LAST  = 3'd5
  } seq_state_e;

  // Cycles allowed for done, or for a single read response, before faulting.
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // Clamp a requested entry count to the table depth.
  function automatic int unsigned clamp_count(input int unsigned req_count,
                                              input int unsigned max_count);
    int unsigned res;
    if (req_count > max_count) begin
      res = max_count;
    end else begin
      res = req_count;
    end
    return res;
  endfunction

endpackage

// File: rtl/fcore_seq_addr_table.sv
// Readback address list: synchronous write port, combinational read port.
module fcore_seq_addr_table #(
  parameter int N_OUTPUTS      = 8,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int IDX_WIDTH      = $clog2(N_OUTPUTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we_i,
  input  logic [IDX_WIDTH-1:0]      waddr_i,
  input  logic [REG_ADDR_WIDTH-1:0] wdata_i,
  input  logic [IDX_WIDTH-1:0]      raddr_i,
  output logic [REG_ADDR_WIDTH-1:0] rdata_o
);

  logic [REG_ADDR_WIDTH-1:0] table_q [N_OUTPUTS];

  // Store one entry per write strobe; indices past the table depth are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUTPUTS; i++) begin
        table_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < N_OUTPUTS)) begin
      table_q[waddr_i] <= wdata_i;
    end
  end

  // Return the addressed entry, or zero for an index past the table depth.
  always_comb begin
    rdata_o = '0;
    if (int'(raddr_i) < N_OUTPUTS) begin
      rdata_o = table_q[raddr_i];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/fcore_run_sequencer.sv
// Pulses the fCore run input per trigger, waits for done, then reads back a
// programmable list of result registers and streams them out with index tags.
module fcore_run_sequencer
  import fcore_sequencer_pkg::*;
#(
  parameter int N_OUTPUTS      = 8,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int DATAPATH_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  // Derived from N_OUTPUTS; not meant to be overridden.
  parameter int IDX_WIDTH      = $clog2(N_OUTPUTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      trigger,
  output logic                      core_run,
  input  logic                      core_done,
  input  logic                      core_fault,
  input  logic                      cfg_we,
  input  logic [IDX_WIDTH-1:0]      cfg_index,
  input  logic [REG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [IDX_WIDTH:0]        cfg_count,
  output logic                      read_request_valid,
  input  logic                      read_request_ready,
  output logic [REG_ADDR_WIDTH-1:0] read_request_data,
  input  logic                      read_response_valid,
  output logic                      read_response_ready,
  input  logic [DATAPATH_WIDTH-1:0] read_response_data,
  output logic                      results_valid,
  input  logic                      results_ready,
  output logic [DATAPATH_WIDTH-1:0] results_data,
  output logic [IDX_WIDTH-1:0]      results_dest,
  output logic                      results_last,
  output logic                      busy,
  output logic                      fault,
  output logic [15:0]               overrun_count
);

  localparam int CNT_W = IDX_WIDTH + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic                      fault_q, fault_d;
  logic [15:0]               ovr_q, ovr_d;
  logic                      res_valid_q, res_valid_d;
  logic [DATAPATH_WIDTH-1:0] res_data_q, res_data_d;
  logic [IDX_WIDTH-1:0]      res_dest_q, res_dest_d;
  logic                      res_last_q, res_last_d;

  logic                      resp_ready_s;
  logic                      resp_hs_s;
  logic                      last_s;
  logic                      timeout_s;
  logic [REG_ADDR_WIDTH-1:0] list_addr_s;

  fcore_seq_addr_table #(
    .N_OUTPUTS      (N_OUTPUTS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_addr_table (
    .clock   (clock),
    .reset   (reset),
    .we_i    (cfg_we),
    .waddr_i (cfg_index),
    .wdata_i (cfg_addr),
    .raddr_i (idx_q),
    .rdata_o (list_addr_s)
  );

  // Next-state, datapath and handshake decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    timer_d     = timer_q;
    fault_d     = fault_q;
    ovr_d       = ovr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_dest_d  = res_dest_q;
    res_last_d  = res_last_q;

    // A response is only taken once the single output slot is free.
    resp_ready_s = (state_q == RESP) && !res_valid_q;
    resp_hs_s    = resp_ready_s && read_response_valid;
    last_s       = ({1'b0, idx_q} == (count_q - CNT_W'(1)));

    // Timeout fires on the last allowed cycle unless the awaited event lands.
    if ((state_q == WAIT_DONE) && !core_done && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_s = 1'b1;
    end else if ((state_q == RESP) && !resp_hs_s && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end

    // Pending beat drains independently of the sequence position.
    if (res_valid_q && results_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    // Triggers arriving mid-sequence are dropped and counted; a faulted block ignores them.
    if (trigger && (state_q != IDLE) && !fault_q && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end else begin
      ovr_d = ovr_q;
    end

    case (state_q)
      IDLE: begin
        if (trigger && !fault_q) begin
          state_d = RUN;
          count_d = CNT_W'(clamp_count(32'(cfg_count), 32'(N_OUTPUTS)));
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        state_d = WAIT_DONE;
        timer_d = '0;
      end
      WAIT_DONE: begin
        if (core_done) begin
          idx_d = '0;
          if (count_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      REQ: begin
        if (read_request_ready) begin
          state_d = RESP;
          timer_d = '0;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (resp_hs_s) begin
          res_valid_d = 1'b1;
          res_data_d  = read_response_data;
          res_dest_d  = idx_q;
          res_last_d  = last_s;
          if (last_s) begin
            state_d = OUT_LAST;
          end else begin
            state_d = REQ;
            idx_d   = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OUT_LAST: begin
        if (res_valid_q && results_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT_LAST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Core fault or timeout aborts the sequence and discards the pending beat.
    if ((state_q != IDLE) && (core_fault || timeout_s)) begin
      state_d     = IDLE;
      fault_d     = 1'b1;
      res_valid_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // State, counters and the single-entry results buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      fault_q     <= 1'b0;
      ovr_q       <= 16'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_dest_q  <= '0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      fault_q     <= fault_d;
      ovr_q       <= ovr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_dest_q  <= res_dest_d;
      res_last_q  <= res_last_d;
    end
  end

  assign core_run            = (state_q == RUN);
  assign busy                = (state_q != IDLE);
  assign fault               = fault_q;
  assign overrun_count       = ovr_q;
  assign read_request_valid  = (state_q == REQ);
  assign read_request_data   = list_addr_s;
  assign read_response_ready = resp_ready_s;
  assign results_valid       = res_valid_q;
  assign results_data        = res_data_q;
  assign results_dest        = res_dest_q;
  assign results_last        = res_last_q;

endmodule

// File: tb/tb_fcore_run_sequencer.sv
// Directed bench for fcore_run_sequencer: one default instance and one with a
// short timeout for the fault path.
module tb_fcore_run_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        trigger, core_run, core_done, core_fault;
  logic        cfg_we;
  logic [2:0]  cfg_index;
  logic [7:0]  cfg_addr;
  logic [3:0]  cfg_count;
  logic        read_request_valid, read_request_ready;
  logic [7:0]  read_request_data;
  logic        read_response_valid, read_response_ready;
  logic [31:0] read_response_data;
  logic        results_valid, results_ready;
  logic [31:0] results_data;
  logic [2:0]  results_dest;
  logic        results_last, busy, fault;
  logic [15:0] overrun_count;

  logic        t_trigger, t_core_run, t_req_valid, t_resp_ready, t_res_valid;
  logic        t_res_last, t_busy, t_fault;
  logic [7:0]  t_req_data;
  logic [31:0] t_res_data;
  logic [2:0]  t_res_dest;
  logic [15:0] t_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fcore_run_sequencer u_dut (
    .clock(clock), .reset(reset), .trigger(trigger), .core_run(core_run),
    .core_done(core_done), .core_fault(core_fault), .cfg_we(cfg_we),
    .cfg_index(cfg_index), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
    .read_request_valid(read_request_valid), .read_request_ready(read_request_ready),
    .read_request_data(read_request_data), .read_response_valid(read_response_valid),
    .read_response_ready(read_response_ready), .read_response_data(read_response_data),
    .results_valid(results_valid), .results_ready(results_ready),
    .results_data(results_data), .results_dest(results_dest),
    .results_last(results_last), .busy(busy), .fault(fault),
    .overrun_count(overrun_count)
  );

  fcore_run_sequencer #(.TIMEOUT_CYCLES(16)) u_dut_to (
    .clock(clock), .reset(reset), .trigger(t_trigger), .core_run(t_core_run),
    .core_done(1'b0), .core_fault(1'b0), .cfg_we(1'b0),
    .cfg_index(3'd0), .cfg_addr(8'd0), .cfg_count(4'd1),
    .read_request_valid(t_req_valid), .read_request_ready(1'b1),
    .read_request_data(t_req_data), .read_response_valid(1'b0),
    .read_response_ready(t_resp_ready), .read_response_data(32'd0),
    .results_valid(t_res_valid), .results_ready(1'b1),
    .results_data(t_res_data), .results_dest(t_res_dest),
    .results_last(t_res_last), .busy(t_busy), .fault(t_fault),
    .overrun_count(t_overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [7:0] addr);
    cfg_we = 1'b1; cfg_index = idx; cfg_addr = addr;
    tick();
    cfg_we = 1'b0;
  endtask

  // Trigger, check the single run pulse, leave the DUT in its first WAIT_DONE cycle.
  task automatic start_run();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("run_pulse", core_run, 1'b1);
    tick();
    chk("run_single", core_run, 1'b0);
  endtask

  // Hold off done for a number of cycles, counting any stray run pulses.
  task automatic finish_done(input int wait_cycles);
    int extra = 0;
    for (int i = 0; i < wait_cycles; i++) begin
      if (core_run) extra++;
      tick();
    end
    chk("no_extra_run", 32'(extra), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!read_request_valid && n < 64) begin
      tick();
      n++;
    end
    if (!read_request_valid) chk("req_wait_expired", read_request_valid, 1'b1);
  endtask

  // One request/response pair with a two-cycle response delay.
  task automatic do_beat(input logic [7:0] addr, input logic [31:0] data,
                         input logic [2:0] dest, input logic last);
    wait_req();
    chk("req_addr", read_request_data, addr);
    tick();
    tick();
    chk("resp_ready", read_response_ready, 1'b1);
    read_response_valid = 1'b1;
    read_response_data  = data;
    tick();
    read_response_valid = 1'b0;
    chk("beat_valid", results_valid, 1'b1);
    chk("beat_data", results_data, data);
    chk("beat_dest", results_dest, dest);
    chk("beat_last", results_last, last);
  endtask

  initial begin
    int stall_bad;
    reset = 1'b1; trigger = 1'b0; core_done = 1'b0; core_fault = 1'b0;
    cfg_we = 1'b0; cfg_index = 3'd0; cfg_addr = 8'd0; cfg_count = 4'd0;
    read_request_ready = 1'b1; read_response_valid = 1'b0;
    read_response_data = 32'd0; results_ready = 1'b1; t_trigger = 1'b0;
    tick(); tick();

    // Reset state.
    chk("rst_busy", busy, 1'b0);
    chk("rst_run", core_run, 1'b0);
    chk("rst_req_valid", read_request_valid, 1'b0);
    chk("rst_resp_ready", read_response_ready, 1'b0);
    chk("rst_res_valid", results_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_overrun", overrun_count, 16'd0);
    reset = 1'b0;
    tick();

    // Basic run: three entries, done 20 cycles after run.
    cfg_write(3'd0, 8'h05);
    cfg_write(3'd1, 8'h12);
    cfg_write(3'd2, 8'h47);
    cfg_count = 4'd3;
    start_run();
    chk("busy_wait", busy, 1'b1);
    finish_done(19);
    do_beat(8'h05, 32'h0000000A, 3'd0, 1'b0);
    do_beat(8'h12, 32'h0000000B, 3'd1, 1'b0);
    do_beat(8'h47, 32'h0000000C, 3'd2, 1'b1);
    chk("busy_out_last", busy, 1'b1);
    tick();
    chk("busy_after_last", busy, 1'b0);
    chk("valid_after_last", results_valid, 1'b0);

    // Backpressure: results stalled for 10 cycles after the first beat.
    results_ready = 1'b0;
    start_run();
    finish_done(3);
    do_beat(8'h05, 32'hD0D0D0D0, 3'd0, 1'b0);
    wait_req();
    chk("bp_req_addr", read_request_data, 8'h12);
    tick();
    read_response_valid = 1'b1;
    read_response_data  = 32'hD1D1D1D1;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_response_ready !== 1'b0 || read_request_valid !== 1'b0 ||
          results_valid !== 1'b1 || results_data !== 32'hD0D0D0D0) stall_bad++;
      tick();
    end
    chk("bp_stall_hold", 32'(stall_bad), 32'd0);
    results_ready = 1'b1;
    tick();
    chk("bp_drained", results_valid, 1'b0);
    chk("bp_resp_ready", read_response_ready, 1'b1);
    tick();
    read_response_valid = 1'b0;
    chk("bp_beat1_data", results_data, 32'hD1D1D1D1);
    chk("bp_beat1_dest", results_dest, 3'd1);
    do_beat(8'h47, 32'hD2D2D2D2, 3'd2, 1'b1);
    tick();
    chk("bp_done", busy, 1'b0);

    // Overrun: three triggers during WAIT_DONE.
    start_run();
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      chk("ovr_no_run", core_run, 1'b0);
      tick();
    end
    chk("ovr_count", overrun_count, 16'd3);
    finish_done(2);
    do_beat(8'h05, 32'h1, 3'd0, 1'b0);
    do_beat(8'h12, 32'h2, 3'd1, 1'b0);
    do_beat(8'h47, 32'h3, 3'd2, 1'b1);
    tick();
    chk("ovr_done", busy, 1'b0);

    // count = 0: done returns straight to IDLE with no request.
    cfg_count = 4'd0;
    start_run();
    finish_done(3);
    chk("cnt0_idle", busy, 1'b0);
    chk("cnt0_no_req", read_request_valid, 1'b0);

    // Count captured at trigger; change during WAIT_DONE has no effect.
    cfg_count = 4'd2;
    start_run();
    cfg_count = 4'd1;
    finish_done(2);
    do_beat(8'h05, 32'h55, 3'd0, 1'b0);
    do_beat(8'h12, 32'h66, 3'd1, 1'b1);
    tick();
    chk("reconf_done", busy, 1'b0);

    // Timeout instance: done never arrives, fault on the 16th WAIT_DONE cycle.
    t_trigger = 1'b1;
    tick();
    t_trigger = 1'b0;
    chk("to_run", t_core_run, 1'b1);
    tick();
    repeat (15) tick();
    chk("to_not_early", t_fault, 1'b0);
    tick();
    chk("to_fault", t_fault, 1'b1);
    chk("to_idle", t_busy, 1'b0);
    t_trigger = 1'b1;
    tick();
    t_trigger = 1'b0;
    chk("to_no_run", t_core_run, 1'b0);
    chk("to_overrun", t_overrun, 16'd0);

    // Async reset in RESP with a pending beat.
    cfg_count = 4'd2;
    results_ready = 1'b0;
    start_run();
    finish_done(1);
    do_beat(8'h05, 32'h77, 3'd0, 1'b0);
    wait_req();
    tick();
    chk("pre_rst_valid", results_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_res_valid", results_valid, 1'b0);
    chk("arst_req_valid", read_request_valid, 1'b0);
    chk("arst_resp_ready", read_response_ready, 1'b0);
    chk("arst_overrun", overrun_count, 16'd0);
    chk("arst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    results_ready = 1'b1;
    cfg_count = 4'd1;
    tick();

    // List cleared by reset; then core_fault in RESP aborts and sticks.
    start_run();
    finish_done(1);
    wait_req();
    chk("arst_list", read_request_data, 8'h00);
    tick();
    core_fault = 1'b1;
    tick();
    core_fault = 1'b0;
    chk("cf_fault", fault, 1'b1);
    chk("cf_idle", busy, 1'b0);
    chk("cf_resp_ready", read_response_ready, 1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("cf_no_run", core_run, 1'b0);
    chk("cf_overrun", overrun_count, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
